mc_datapath: RTL

- Parametrised multi-cycle successor to the single-cycle extended datapath.
- Holds the PC, a register file, an extended ALU, branch/jump/jal logic and a sequencer FSM.
- Accepts one decoded instruction per valid/ready handshake and talks to data memory over a req/ready handshake.
- Sits between the control decoder and the data memory/bus in the extended-CPU build.

---
 rtl/mc_datapath.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mc_datapath.sv
// mc_datapath: multi-cycle datapath with PC, register file, extended ALU and sequencer FSM.
// Defining MC_DATAPATH_OVF_TRAP_EN makes add/sub overflow trap to EXC_VEC and adds the sticky exc output.
//
// state | meaning
// IDLE  | inst_ready high; accept instruction, capture controls, read rs/rt
// EX    | register ALU result, zero, overflow and store data (rt)
// MEM   | hold mem_req/mem_we until mem_ready; capture load data
// WB    | done pulse; register write-back and PC update on the exit edge
module mc_datapath #(
    parameter int                DATA_W   = 32,
    parameter int                REG_AW   = 5,
    parameter logic [DATA_W-1:0] RESET_PC = '0,
    parameter logic [DATA_W-1:0] EXC_VEC  = 32'h0000_0180
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inst_valid,
    output logic              inst_ready,
    input  logic [25:0]       inst_field,
    input  logic [2:0]        ALU_Control,
    input  logic              ALUSrc_B,
    input  logic              RegDst,
    input  logic              RegWrite,
    input  logic [1:0]        DatatoReg,
    input  logic [1:0]        Branch,
    input  logic              Jal,
    input  logic              MemRead,
    input  logic              MemWrite,
    output logic              mem_req,
    output logic              mem_we,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] Data_in,
    output logic [DATA_W-1:0] Data_out,
    output logic [DATA_W-1:0] ALU_out,
    output logic [DATA_W-1:0] PC_out,
    output logic              zero,
    output logic              overflow,
    output logic              done
`ifdef MC_DATAPATH_OVF_TRAP_EN
    ,
    output logic              exc
`endif
);

    localparam int NREG = 2 ** REG_AW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EX   = 2'd1,
        S_MEM  = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [25:0]       ir;
    logic [2:0]        c_alu;
    logic              c_srcb;
    logic              c_regdst;
    logic              c_regwr;
    logic [1:0]        c_d2r;
    logic [1:0]        c_br;
    logic              c_jal;
    logic              c_mr;
    logic              c_mw;

    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] din_q;
    logic [DATA_W-1:0] pc_q;
    logic              trap_q;

    logic [NREG-1:0][DATA_W-1:0] rf;

    logic [REG_AW-1:0] rs_addr;
    logic [REG_AW-1:0] rt_addr;
    logic [REG_AW-1:0] c_rt;
    logic [REG_AW-1:0] c_rd;
    logic [REG_AW-1:0] wb_addr;

    logic [4:0]        shamt;
    logic [15:0]       imm;
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] b_op;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic [DATA_W-1:0] alu_res;
    logic              alu_ovf;
    logic              trap_now;
    logic              mem_op;

    logic [DATA_W-1:0] pc4;
    logic [DATA_W-1:0] pc_nxt;
    logic [DATA_W-1:0] wb_data;
    logic              wb_we;
    logic              taken;

    assign rs_addr  = REG_AW'(inst_field[25:21]);
    assign rt_addr  = REG_AW'(inst_field[20:16]);
    assign c_rt     = REG_AW'(ir[20:16]);
    assign c_rd     = REG_AW'(ir[15:11]);
    assign shamt    = ir[10:6];
    assign imm      = ir[15:0];
    assign imm_sext = {{(DATA_W-16){imm[15]}}, imm};
    assign b_op     = c_srcb ? imm_sext : b_q;
    assign sum      = a_q + b_op;
    assign diff     = a_q - b_op;
    assign mem_op   = c_mr | c_mw;
    assign PC_out   = pc_q;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (c_alu)
            3'b000: alu_res = a_q & b_op;
            3'b001: alu_res = a_q | b_op;
            3'b010: begin
                alu_res = sum;
                alu_ovf = (a_q[DATA_W-1] == b_op[DATA_W-1]) && (sum[DATA_W-1] != a_q[DATA_W-1]);
            end
            3'b011: alu_res = a_q ^ b_op;
            3'b100: alu_res = ~(a_q | b_op);
            3'b101: alu_res = b_op >> shamt;
            3'b110: begin
                alu_res = diff;
                alu_ovf = (a_q[DATA_W-1] != b_op[DATA_W-1]) && (diff[DATA_W-1] != a_q[DATA_W-1]);
            end
            default: alu_res = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_op))};
        endcase
    end

`ifdef MC_DATAPATH_OVF_TRAP_EN
    assign trap_now = alu_ovf;
`else
    assign trap_now = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        inst_ready = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                inst_ready = 1'b1;
                if (inst_valid) state_nxt = S_EX;
            end
            S_EX: begin
                state_nxt = (mem_op && !trap_now) ? S_MEM : S_WB;
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = c_mw;
                if (mem_ready) state_nxt = S_WB;
            end
            S_WB: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Write-back and next-PC selection, consumed on the WB exit edge.
    always_comb begin
        pc4     = pc_q + DATA_W'(4);
        wb_addr = c_jal ? {REG_AW{1'b1}} : (c_regdst ? c_rd : c_rt);
        wb_we   = (c_regwr | c_jal) && !trap_q && (wb_addr != '0);
        case (c_d2r)
            2'b00:   wb_data = ALU_out;
            2'b01:   wb_data = din_q;
            2'b10:   wb_data = DATA_W'({imm, 16'h0000});
            default: wb_data = pc4;
        endcase
        taken = ((c_br == 2'b01) && zero) || ((c_br == 2'b10) && !zero);
        if (trap_q)
            pc_nxt = EXC_VEC;
        else if (c_jal || (c_br == 2'b11))
            pc_nxt = {pc4[DATA_W-1:28], ir, 2'b00};
        else if (taken)
            pc_nxt = pc4 + (imm_sext << 2);
        else
            pc_nxt = pc4;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir       <= '0;
            c_alu    <= '0;
            c_srcb   <= 1'b0;
            c_regdst <= 1'b0;
            c_regwr  <= 1'b0;
            c_d2r    <= '0;
            c_br     <= '0;
            c_jal    <= 1'b0;
            c_mr     <= 1'b0;
            c_mw     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            din_q    <= '0;
            pc_q     <= RESET_PC;
            trap_q   <= 1'b0;
            rf       <= '0;
            ALU_out  <= '0;
            Data_out <= '0;
            zero     <= 1'b0;
            overflow <= 1'b0;
`ifdef MC_DATAPATH_OVF_TRAP_EN
            exc      <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (inst_valid) begin
                        ir       <= inst_field;
                        c_alu    <= ALU_Control;
                        c_srcb   <= ALUSrc_B;
                        c_regdst <= RegDst;
                        c_regwr  <= RegWrite;
                        c_d2r    <= DatatoReg;
                        c_br     <= Branch;
                        c_jal    <= Jal;
                        c_mr     <= MemRead;
                        c_mw     <= MemWrite;
                        a_q      <= rf[rs_addr];
                        b_q      <= rf[rt_addr];
                    end
                end
                S_EX: begin
                    ALU_out  <= alu_res;
                    zero     <= (alu_res == '0);
                    overflow <= alu_ovf;
                    Data_out <= b_q;
                    trap_q   <= trap_now;
                end
                S_MEM: begin
                    // Both MemRead and MemWrite high behaves as a plain store.
                    if (mem_ready && c_mr && !c_mw) din_q <= Data_in;
                end
                S_WB: begin
                    if (wb_we) rf[wb_addr] <= wb_data;
                    pc_q <= pc_nxt;
`ifdef MC_DATAPATH_OVF_TRAP_EN
                    if (trap_q) exc <= 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
